// File: rtl/boa_mem_pkg.sv
// Shared types and helpers for the Boa memory bus responders.
package boa_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } boa_sram_state_t;

  // Number of byte-offset address bits covered by one data word.
  function automatic int boa_mem_lsb(input int dlen);
    return $clog2(dlen / 8);
  endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Boa memory bus: CPU-side initiator drives the request, MEM side responds.
interface boa_mem_bus #(
  parameter int alen = 32,
  parameter int dlen = 32
);
  logic            re;
  logic            we;
  logic [alen-1:2] addr;
  logic [dlen-1:0] wdata;
  logic            ready;
  logic [dlen-1:0] rdata;

  modport MEM (input re, we, addr, wdata, output ready, rdata);
  modport CPU (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/boa_sram_array.sv
// Single-port synchronous word array with registered, read-before-write output.
// Contents are not reset so the array maps onto block RAM.
module boa_sram_array #(
  parameter int dlen  = 32,
  parameter int depth = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] idx,
  input  logic [dlen-1:0]          wdata,
  output logic [dlen-1:0]          rdata
);

  logic [dlen-1:0] mem_q [depth];

  // Write the addressed word and register its old contents every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/boa_sram_responder.sv
// Boa MEM-side SRAM responder: samples a request in IDLE, waits latency-1
// cycles, then pulses ready for one cycle.
// Optional feature: define BOA_SRAM_BOUNDS_EN to reject addresses with any
// bit set above the word-index field (writes dropped, reads return 0).
module boa_sram_responder
  import boa_mem_pkg::*;
#(
  parameter int alen    = 32,
  parameter int dlen    = 32,
  parameter int depth   = 1024,
  parameter int latency = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  boa_mem_bus.MEM bus
);

  localparam int          LSB      = boa_mem_lsb(dlen);
  localparam int          IDX_BITS = $clog2(depth);
  localparam logic [3:0]  LAT_M1   = 4'(latency - 1);

  boa_sram_state_t     state_q;
  logic [3:0]          cnt_q;
  logic                ready_q;
  logic                live_q;
  logic                oob_q;
  logic [dlen-1:0]     hold_q;
  logic [dlen-1:0]     arr_rdata;
  logic [IDX_BITS-1:0] idx;
  logic                sample;
  logic                in_range;
  logic                arr_we;
  logic                unused_addr;

  assign idx         = bus.addr[LSB+IDX_BITS-1:LSB];
  assign sample      = (state_q == IDLE) && (bus.re || bus.we);
  assign arr_we      = sample && bus.we && in_range;
  assign unused_addr = ^bus.addr;

`ifdef BOA_SRAM_BOUNDS_EN
  generate
    if (alen > LSB + IDX_BITS) begin : g_bounds
      assign in_range = ~|bus.addr[alen-1:LSB+IDX_BITS];
    end else begin : g_no_upper
      assign in_range = 1'b1;
    end
  endgenerate
`else
  // Upper address bits are ignored; accesses alias modulo depth.
  assign in_range = 1'b1;
`endif

  boa_sram_array #(
    .dlen  (dlen),
    .depth (depth)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (idx),
    .wdata (bus.wdata),
    .rdata (arr_rdata)
  );

  // Request FSM with wait-state counter and registered ready pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.re || bus.we) begin
            cnt_q <= LAT_M1;
            if (LAT_M1 != 4'd0) begin
              state_q <= WAIT;
            end else begin
              state_q <= RESP;
              ready_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            ready_q <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The array output is live for one cycle after a read is sampled; it is
  // then frozen in hold_q so rdata only changes when the next read is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
      oob_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      live_q <= sample && bus.re;
      if (sample && bus.re) begin
        oob_q <= ~in_range;
      end
      if (live_q) begin
        hold_q <= oob_q ? '0 : arr_rdata;
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = live_q ? (oob_q ? '0 : arr_rdata) : hold_q;

endmodule
